// File: rtl/des_pkg.sv
// des_pkg: DES tables, search FSM states and key/permutation helpers
package des_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, CHECK, FOUND, EXHAUSTED} state_t;
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                              12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                              22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  // Tables number bits 1..N from the MSB, hence the W - T[i] indexing below.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction
  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction
  // Each 6-bit group picks row {b1,b6} and column b2..b5 of its S-box.
  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0] b;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      y[31-4*j -: 4] = 4'(SBOX_T[j][{b[5], b[0], b[4:1]}]);
    end
    return y;
  endfunction
  // C occupies cd[55:28], D cd[27:0]; both halves rotate left independently.
  function automatic logic [55:0] rotate_cd(input logic [55:0] cd, input int n);
    return n == 2 ? {cd[53:28], cd[55:54], cd[25:0], cd[27:26]}
                  : {cd[54:28], cd[55], cd[26:0], cd[27]};
  endfunction
  // Seven key bits per byte in the upper positions, odd parity in bit 0.
  function automatic logic [63:0] expand_key(input logic [55:0] c);
    logic [63:0] k;
    for (int i = 0; i < 8; i++) begin
      k[8*i+1 +: 7] = c[7*i +: 7];
      k[8*i] = ~^c[7*i +: 7];
    end
    return k;
  endfunction
endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);
  assign l_next = r;
  assign r_next = l ^ perm_p(sbox(perm_e(r) ^ subkey));
endmodule

// File: rtl/des_key_search_top.sv
// des_key_search_top: brute-force DES known-plaintext key search, one round per clock
module des_key_search_top
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [63:0] plaintext,
  input  logic [63:0] ciphertext,
  output logic [55:0] count,
  output logic [63:0] Key,
  output logic        keyFound
);
  state_t state, state_next;
  logic [31:0] l, r, l_next, r_next;
  logic [55:0] cd, cd_shift;
  logic [47:0] subkey;
  logic [3:0] round;
  logic match;
  assign Key = expand_key(count);
  assign cd_shift = rotate_cd(cd, SHIFT_T[round]);
  assign subkey = perm_pc2(cd_shift);
  assign match = perm_fp({r, l}) == ciphertext;
  assign keyFound = state == FOUND;
  des_round u_round (.l(l), .r(r), .subkey(subkey), .l_next(l_next), .r_next(r_next));
  // Search sequencing: load, 16 rounds, check, then next key or terminal state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = Start ? LOAD : IDLE;
      LOAD:    state_next = ROUND;
      ROUND:   state_next = round == 4'd15 ? CHECK : ROUND;
      CHECK:   state_next = match ? FOUND : count == '1 ? EXHAUSTED : LOAD;
      default: state_next = state;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // Datapath: block load, round iteration and key counter advance
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      l <= '0;
      r <= '0;
      cd <= '0;
      round <= '0;
    end else begin
      if (state == LOAD) begin
        {l, r} <= perm_ip(plaintext);
        cd <= perm_pc1(Key);
        round <= '0;
      end
      if (state == ROUND) begin
        l <= l_next;
        r <= r_next;
        cd <= cd_shift;
        round <= round + 4'd1;
      end
      if (state == CHECK && !match && count != '1) count <= count + 56'd1;
    end
endmodule

// File: tb/tb_des_key_search_top.sv
// tb_des_key_search_top: directed + randomized checks of search timing, key expansion and found flag
module tb_des_key_search_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] plaintext = '0;
  logic [63:0] ciphertext = '0;
  logic [55:0] count;
  logic [63:0] key;
  logic key_found;
  int total = 0;
  int bad = 0;
  logic [63:0] kat_pt [2] = '{64'h95F8A5E5DD31D900, 64'h8000000000000000};
  logic [63:0] kat_ct [2] = '{64'h8000000000000000, 64'h95F8A5E5DD31D900};

  always #5 clk = ~clk;

  des_key_search_top dut (
    .clk(clk), .reset(rst_n), .Start(start), .plaintext(plaintext), .ciphertext(ciphertext),
    .count(count), .Key(key), .keyFound(key_found));

  // Reference key: 7-bit chunk shifted up one place, low bit set when the chunk has even weight.
  function automatic logic [63:0] ref_key(input longint unsigned n);
    logic [63:0] k;
    int b;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      b = int'((n >> (7 * i)) & 64'h7f);
      k = k | (64'((b * 2) + (($countones(b) % 2 == 0) ? 1 : 0)) << (8 * i));
    end
    return k;
  endfunction

  task automatic check(input string tag, input longint unsigned exp_count, input logic exp_found);
    logic [55:0] ec;
    logic [63:0] ek;
    ec = exp_count[55:0];
    ek = ref_key(exp_count);
    total++;
    assert (count === ec) else begin
      bad++;
      $error("FAIL %s count got=%h exp=%h", tag, count, ec);
    end
    total++;
    assert (key === ek) else begin
      bad++;
      $error("FAIL %s Key got=%h exp=%h", tag, key, ek);
    end
    total++;
    assert (key_found === exp_found) else begin
      bad++;
      $error("FAIL %s keyFound got=%b exp=%b", tag, key_found, exp_found);
    end
  endtask

  // Reset is applied with Start high; outputs must stay at reset values until release.
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    #1 check("reset_async", 0, 1'b0);
    repeat (hold) @(negedge clk);
    check("reset_hold", 0, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle", 0, 1'b0);
  endtask

  // Raise Start just before edge 0; after edge e, a key at index n is found once e >= 18(n+1),
  // otherwise count = floor(e/18). n < 0 means no matching key in range.
  task automatic run(input string tag, input logic [63:0] pt, input logic [63:0] ct, input int n,
                     input int start_len, input int edges, input bit sparse);
    logic found;
    longint unsigned exp;
    plaintext = pt;
    ciphertext = ct;
    start = 1'b1;
    for (int e = 0; e < edges; e++) begin
      @(negedge clk);
      if (e == start_len - 1) start = 1'b0;
      found = n >= 0 && e >= 18 * (n + 1);
      exp = found ? longint'(n) : longint'(e / 18);
      if (!sparse || e % 18 == 0 || e % 18 == 17 || e == edges - 1) check(tag, exp, found);
    end
    start = 1'b0;
  endtask

  initial begin
    int idx;
    do_reset(3);
    run("kat0", 64'h95F8A5E5DD31D900, 64'h8000000000000000, 0, 1000, 40, 1'b0);
    do_reset(2);
    run("low_key", 64'h2c2f4516bcea4a32, 64'h9bd53434a55cd2e5, 37, 2000, 18 * 38 + 80, 1'b0);
    do_reset(2);
    run("pulse", 64'h2c2f4516bcea4a32, 64'h9bd53434a55cd2e5, 37, 1, 18 * 38 + 20, 1'b0);
    do_reset(2);
    run("abort_pre", 64'h2c2f4516bcea4a32, 64'h9bd53434a55cd2e5, 37, 2000, 300, 1'b0);
    do_reset(2);
    run("abort_post", 64'h2c2f4516bcea4a32, 64'h9bd53434a55cd2e5, 37, 5, 18 * 38 + 20, 1'b0);
    for (int t = 0; t < 4; t++) begin
      idx = int'($urandom_range(0, 1));
      do_reset(int'($urandom_range(1, 4)));
      run("kat_rand", kat_pt[idx], kat_ct[idx], 0, int'($urandom_range(1, 25)), 40, 1'b0);
    end
    do_reset(2);
    run("no_match", {$urandom, $urandom}, {$urandom, $urandom}, -1, int'($urandom_range(1, 20)),
        18 * 2048 + 5, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
